// File: rtl/seq_det_prog_fsm.sv
// rtl/seq_det_prog_fsm.sv - runtime-programmable serial sequence detector (Moore)
// Pattern, length and overlap mode are loadable; matches are counted with saturation.
module seq_det_prog_fsm #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 CNT_W           = 16,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
  parameter int                 DEFAULT_LEN     = 4,
  parameter bit                 DEFAULT_OVERLAP = 1'b1,
  localparam int                LW              = $clog2(MAX_LEN+1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               sequence_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_len_err
);

  typedef enum logic [1:0] {IDLE, FILL, HUNT, MATCH} state_t;

  state_t             state;
  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      len;
  logic               overlap;

  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill_inc;
  logic               match;
  logic               accept;
  logic               enter_match;
  logic               cfg_legal;

  always_comb begin
    new_hist = {hist, sequence_in};
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len);
    end
    fill_inc    = (fill >= len) ? len : fill + LW'(1);
    match       = (fill_inc >= len) && (((new_hist ^ pattern) & mask) == '0);
    accept      = in_valid && !cfg_load;
    enter_match = accept && match;
    cfg_legal   = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hist         <= '0;
      fill         <= '0;
      pattern      <= DEFAULT_PATTERN;
      len          <= LW'(DEFAULT_LEN);
      overlap      <= DEFAULT_OVERLAP;
      detector_out <= 1'b0;
      cfg_len_err  <= 1'b0;
    end else if (cfg_load) begin
      // The in-flight serial bit is dropped whether or not the load is legal.
      if (cfg_legal) begin
        pattern      <= cfg_pattern;
        len          <= cfg_len;
        overlap      <= cfg_overlap;
        hist         <= '0;
        fill         <= '0;
        state        <= IDLE;
        detector_out <= 1'b0;
        cfg_len_err  <= 1'b0;
      end else begin
        cfg_len_err  <= 1'b1;
      end
    end else begin
      cfg_len_err <= 1'b0;
      if (in_valid) begin
        hist <= new_hist[MAX_LEN-2:0];
        if (match) begin
          state        <= MATCH;
          detector_out <= 1'b1;
          fill         <= overlap ? fill_inc : '0;
        end else begin
          state        <= (fill_inc == len) ? HUNT : FILL;
          detector_out <= 1'b0;
          fill         <= fill_inc;
        end
      end else begin
        detector_out <= (state == MATCH);
      end
    end
  end

  // Clear wins over increment, but a match in the clearing cycle still counts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
    end else if (count_clr) begin
      match_count <= enter_match ? CNT_W'(1) : '0;
    end else if (enter_match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_det_prog_fsm.sv
// tb/tb_seq_det_prog_fsm.sv - scoreboard bench for seq_det_prog_fsm
// Two instances (16-bit and 2-bit counters) share stimulus; a queue-based model predicts outputs.
module tb_seq_det_prog_fsm;
  localparam int MAX_LEN = 8;
  localparam int LW      = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              sequence_in = 1'b0;
  logic              cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]     cfg_len = '0;
  logic              cfg_overlap = 1'b0;
  logic              count_clr = 1'b0;
  logic              det_a, err_a, det_b, err_b;
  logic [15:0]       cnt_a;
  logic [1:0]        cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  seq_det_prog_fsm #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .sequence_in(sequence_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .detector_out(det_a), .match_count(cnt_a), .cfg_len_err(err_a)
  );

  seq_det_prog_fsm #(.MAX_LEN(8), .CNT_W(2)) dut_small (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .sequence_in(sequence_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .detector_out(det_b), .match_count(cnt_b), .cfg_len_err(err_b)
  );

  typedef struct packed {
    logic        det;
    logic [15:0] c16;
    logic [1:0]  c2;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // Reference model: bits received since the last restart, newest at the back.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  bit         m_det;
  int         m_c16;
  int         m_c2;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.det = m_det;
    e.c16 = 16'(m_c16);
    e.c2  = 2'(m_c2);
    e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_pat = 8'b0000_1011;
    m_len = 4;
    m_ovl = 1'b1;
    m_q.delete();
    m_det = 1'b0;
    m_c16 = 0;
    m_c2  = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit load, input logic [7:0] pat,
                            input int len, input bit ovl, input bit clr);
    bit hit;
    hit   = 1'b0;
    m_err = 1'b0;
    if (load) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_pat = pat;
        m_len = len;
        m_ovl = ovl;
        m_q.delete();
        m_det = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (v) begin
      m_q.push_back(b);
      while (m_q.size() > m_len) void'(m_q.pop_front());
      hit = (m_q.size() == m_len);
      for (int k = 0; k < m_q.size(); k++)
        if (m_q[k] != m_pat[m_len-1-k]) hit = 1'b0;
      m_det = hit;
      if (hit && !m_ovl) m_q.delete();
    end
    if (clr) begin
      m_c16 = hit ? 1 : 0;
      m_c2  = hit ? 1 : 0;
    end else if (hit) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c2 < 3) m_c2++;
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit load, input logic [7:0] pat,
                       input int len, input bit ovl, input bit clr);
    @(negedge clock);
    reset_n     = 1'b1;
    in_valid    = v;
    sequence_in = b;
    cfg_load    = load;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_overlap = ovl;
    count_clr   = clr;
    model_step(v, b, load, pat, len, ovl, clr);
    push_exp();
  endtask

  task automatic bit_in(input bit b);
    drive(1'b1, b, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [7:0] pat, input int len, input bit ovl);
    drive(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    sequence_in = 1'b0;
    cfg_load    = 1'b0;
    count_clr   = 1'b0;
    model_reset();
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("detector_out", 32'(det_a), 32'(e.det));
        chk("match_count", 32'(cnt_a), 32'(e.c16));
        chk("cfg_len_err", 32'(err_a), 32'(e.err));
        chk("small_detector_out", 32'(det_b), 32'(e.det));
        chk("small_match_count", 32'(cnt_b), 32'(e.c2));
      end
    end
  end

  initial begin : stimulus
    model_reset();
    #22;
    chk("reset_detector_out", 32'(det_a), 32'd0);
    chk("reset_match_count", 32'(cnt_a), 32'd0);
    chk("reset_cfg_len_err", 32'(err_a), 32'd0);
    chk("reset_small_count", 32'(cnt_b), 32'd0);

    // Defaults, overlapping: 1011011 matches after bits 4 and 7.
    send_bits(8'b0101_1011, 7);
    gap(2);

    // Non-overlapping: only one match on the same stream.
    load_cfg(8'b0000_1011, 4, 1'b0);
    send_bits(8'b0101_1011, 7);
    gap(2);

    // Valid gaps between bits; output held through idle cycles after the match.
    load_cfg(8'b0000_1011, 4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      bit_in(i != 2);
      gap(3);
    end
    gap(3);

    // Full-length pattern, then an illegal length that must not disturb anything.
    load_cfg(8'hA5, 8, 1'b1);
    send_bits(8'hA5, 8);
    load_cfg(8'h3C, 9, 1'b0);
    gap(1);
    send_bits(8'hA5, 8);
    load_cfg(8'h00, 0, 1'b0);
    gap(1);

    // Reset mid-sequence loses the partial match.
    send_bits(8'b0000_0101, 3);
    pulse_reset();
    bit_in(1'b1);
    gap(2);

    // Single-bit pattern, counter saturation and clear-with-match.
    load_cfg(8'h01, 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) bit_in(1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    gap(1);

    // Randomized traffic with occasional reconfiguration, clears and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else if ($urandom_range(0, 24) == 0) begin
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1,
              8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0, 8'h00, 0, 1'b0,
              $urandom_range(0, 49) == 0);
      end
    end
    gap(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
